// File: rtl/secuenciador_registros_rtc_pkg.sv
// Shared definitions for the RTC register sequencer: FSM states, register
// indices, configuration group codes and mask helpers.
package secuenciador_registros_rtc_pkg;

    localparam int MASK_W = 10;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } estado_e;

    // Register map walked by the sequencer
    localparam logic [IDX_W-1:0] IDX_SEG_HORA    = 4'd0;
    localparam logic [IDX_W-1:0] IDX_MIN_HORA    = 4'd1;
    localparam logic [IDX_W-1:0] IDX_HORA_HORA   = 4'd2;
    localparam logic [IDX_W-1:0] IDX_DIA_FECHA   = 4'd3;
    localparam logic [IDX_W-1:0] IDX_MES_FECHA   = 4'd4;
    localparam logic [IDX_W-1:0] IDX_JAHR_FECHA  = 4'd5;
    localparam logic [IDX_W-1:0] IDX_DIA_SEMANA  = 4'd6;
    localparam logic [IDX_W-1:0] IDX_SEG_TIMER   = 4'd7;
    localparam logic [IDX_W-1:0] IDX_MIN_TIMER   = 4'd8;
    localparam logic [IDX_W-1:0] IDX_HORA_TIMER  = 4'd9;

    // Configuration group codes on funcion_conf
    localparam logic [2:0] GRUPO_HORA  = 3'b001;
    localparam logic [2:0] GRUPO_FECHA = 3'b010;
    localparam logic [2:0] GRUPO_TIMER = 3'b100;

    // Register sets owned by each group
    localparam logic [MASK_W-1:0] MASCARA_HORA  = 10'b00_0000_0111;
    localparam logic [MASK_W-1:0] MASCARA_FECHA = 10'b00_0111_1000;
    localparam logic [MASK_W-1:0] MASCARA_TIMER = 10'b11_1000_0000;

    // Lowest set bit of a mask; MSB of the result flags "found".
    function automatic logic [IDX_W:0] primer_bit(input logic [MASK_W-1:0] mascara);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mascara[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // Lowest set bit strictly above 'actual'; MSB flags "found".
    // For actual = 9 the shift overflows to zero, which masks everything out.
    function automatic logic [IDX_W:0] siguiente_bit(input logic [MASK_W-1:0] mascara,
                                                     input logic [IDX_W-1:0]  actual);
        logic [MASK_W-1:0] hasta_actual;
        hasta_actual = (MASK_W'(2) << actual) - MASK_W'(1);
        return primer_bit(mascara & ~hasta_actual);
    endfunction

endpackage

// File: rtl/secuenciador_registros_rtc_mascara.sv
// Combinational decode of the configuration group into the 10-bit edit mask.
// Unknown or multi-hot codes select no registers.
module mascara_grupo_rtc
    import secuenciador_registros_rtc_pkg::*;
(
    input  logic [2:0]        funcion_conf,
    output logic [MASK_W-1:0] mascara_edicion
);

    // Group code to register set
    always_comb begin
        mascara_edicion = '0;
        case (funcion_conf)
            GRUPO_HORA:  mascara_edicion = MASCARA_HORA;
            GRUPO_FECHA: mascara_edicion = MASCARA_FECHA;
            GRUPO_TIMER: mascara_edicion = MASCARA_TIMER;
            default:     mascara_edicion = '0;
        endcase
    end

endmodule

// File: rtl/secuenciador_registros_rtc.sv
// RTC register sequencer: walks the RTC register map issuing one bus
// transaction per selected register. A commit writes the group being edited;
// a refresh tick reads every register outside that group.
// Optional watchdog on bus_done: define SECUENCIADOR_TIMEOUT_EN.
//
// Bus handshake: bus_start pulses for one cycle to launch a transaction on
// idx_reg with direction bus_wr; the driver answers with a one-cycle bus_done
// pulse, which is only honoured while the FSM waits for it. In a read sweep
// ld_reg pulses the cycle after bus_done, with idx_reg still on that register.
module secuenciador_registros_rtc
    import secuenciador_registros_rtc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        funcion_conf,
    input  logic              tick_refresco,
    input  logic              commit,
    input  logic              bus_done,
    output logic              bus_start,
    output logic              bus_wr,
    output logic [IDX_W-1:0]  idx_reg,
    output logic              ld_reg,
    output logic              busy,
    output logic              err_timeout,
    output estado_e           estado
);

    estado_e            estado_q, estado_d;
    logic [MASK_W-1:0]  mascara_edicion;
    logic [MASK_W-1:0]  mascara_inicio;
    logic [MASK_W-1:0]  mascara_sweep;
    logic [IDX_W-1:0]   idx_q;
    logic               bus_wr_q;
    logic               pend_tick;
    logic               pend_commit;
    logic               edicion_valida;
    logic               commit_go;
    logic               tick_go;
    logic               arranque;
    logic               timeout_hit;
    logic [IDX_W:0]     inicio;
    logic [IDX_W:0]     siguiente;

    mascara_grupo_rtc u_mascara (
        .funcion_conf    (funcion_conf),
        .mascara_edicion (mascara_edicion)
    );

    // Request arbitration: commit (live or pending) beats the refresh tick
    assign edicion_valida = |mascara_edicion;
    assign commit_go      = (commit | pend_commit) & edicion_valida;
    assign tick_go        = tick_refresco | pend_tick;
    assign mascara_inicio = commit_go ? mascara_edicion : ~mascara_edicion;
    assign inicio         = primer_bit(mascara_inicio);
    assign arranque       = (commit_go | tick_go) & inicio[IDX_W];
    assign siguiente      = siguiente_bit(mascara_sweep, idx_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado_q <= ST_IDLE;
        else        estado_q <= estado_d;
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE:  if (arranque) estado_d = ST_START;
            ST_START: estado_d = ST_WAIT;
            ST_WAIT: begin
                if (bus_done)         estado_d = ST_NEXT;
                else if (timeout_hit) estado_d = ST_IDLE;
            end
            ST_NEXT:  estado_d = siguiente[IDX_W] ? ST_START : ST_IDLE;
            default:  estado_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state plus the sweep registers
    always_comb begin
        bus_start = (estado_q == ST_START);
        ld_reg    = (estado_q == ST_NEXT) && !bus_wr_q;
        busy      = (estado_q != ST_IDLE);
        bus_wr    = bus_wr_q;
        idx_reg   = idx_q;
        estado    = estado_q;
    end

    // Sweep datapath: latched mask, current index, direction, pending requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mascara_sweep <= '0;
            idx_q         <= '0;
            bus_wr_q      <= 1'b0;
            pend_tick     <= 1'b0;
            pend_commit   <= 1'b0;
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    // A pending commit is either serviced now or dropped
                    // because the group no longer selects anything.
                    pend_commit <= 1'b0;
                    // A tick that lost to a commit stays pending.
                    pend_tick   <= commit_go & tick_go;
                    if (arranque) begin
                        mascara_sweep <= mascara_inicio;
                        idx_q         <= inicio[IDX_W-1:0];
                        bus_wr_q      <= commit_go;
                    end
                end
                ST_WAIT: begin
                    if (timeout_hit) bus_wr_q <= 1'b0;
                end
                ST_NEXT: begin
                    if (siguiente[IDX_W]) idx_q    <= siguiente[IDX_W-1:0];
                    else                  bus_wr_q <= 1'b0;
                end
                default: ;
            endcase
            // Requests arriving mid-sweep collapse into one-deep flags
            if (estado_q != ST_IDLE) begin
                if (tick_refresco)                pend_tick   <= 1'b1;
                if (commit && edicion_valida)     pend_commit <= 1'b1;
            end
        end
    end

`ifdef SECUENCIADOR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_wait;
    logic             err_q;

    // Cycles spent in the current WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   cnt_wait <= '0;
        else if (estado_q == ST_WAIT) cnt_wait <= cnt_wait + CNT_W'(1);
        else                          cnt_wait <= '0;
    end

    // Last WAIT cycle with no bus_done aborts the sweep
    assign timeout_hit = (estado_q == ST_WAIT) && !bus_done &&
                         (cnt_wait == CNT_W'(TIMEOUT_CYC - 1));

    // Sticky error, cleared when a sweep runs to completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        err_q <= 1'b0;
        else if (timeout_hit)                              err_q <= 1'b1;
        else if ((estado_q == ST_NEXT) && !siguiente[IDX_W]) err_q <= 1'b0;
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;

    // TIMEOUT_CYC only matters when the watchdog is built in
    if (TIMEOUT_CYC < 1) begin : g_timeout_sin_uso
    end
`endif

endmodule

// File: doc/secuenciador_registros_rtc.md
SECUENCIADOR_REGISTROS_RTC -- requirements
Module: secuenciador_registros_rtc

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, bus_done wait limit in clk cycles (used only with watchdog).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port funcion_conf  input  3  configuration group: 001 hora, 010 fecha, 100 timer, others none.
REQ-005 SHALL have port tick_refresco  input  1  one-cycle pulse requesting a read sweep.
REQ-006 SHALL have port commit  input  1  one-cycle pulse requesting a write sweep of the edited group.
REQ-007 SHALL have port bus_done  input  1  one-cycle pulse from bus driver, transaction complete.
REQ-008 SHALL have port bus_start  output  1  one-cycle pulse launching a transaction.
REQ-009 SHALL have port bus_wr  output  1  1 write, 0 read; valid while busy.
REQ-010 SHALL have port idx_reg  output  4  register index 0..9: seg/min/hora_hora, dia/mes/jahr_fecha, dia_semana, seg/min/hora_timer.
REQ-011 SHALL have port ld_reg  output  1  one-cycle pulse to latch read data for idx_reg.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port err_timeout  output  1  sticky watchdog error flag.

Function
REQ-014 SHALL compute edit mask (10 bits): 001 -> idx 0-2; 010 -> idx 3-6; 100 -> idx 7-9; other codes -> empty.
REQ-015 SHALL use read mask = ~edit mask, write mask = edit mask, latched at sweep start and held for the whole sweep.
REQ-016 SHALL implement states IDLE, START, WAIT, NEXT.
REQ-017 IDLE: commit with non-empty edit mask -> START with bus_wr=1; else tick_refresco -> START with bus_wr=0; idx_reg = lowest set bit of latched mask.
REQ-018 SHALL give commit priority over tick_refresco when both occur in the same IDLE cycle; the tick is then held pending.
REQ-019 START: bus_start=1 for exactly one cycle -> WAIT.
REQ-020 WAIT: on bus_done -> NEXT; in a read sweep, ld_reg=1 in the NEXT cycle with idx_reg unchanged.
REQ-021 NEXT: idx_reg advances to next higher set mask bit -> START; none left -> IDLE.
REQ-022 SHALL keep one-deep pending flags for tick_refresco and commit arriving while busy; serviced in IDLE with commit first; repeats while pending collapse.
REQ-023 commit with empty edit mask SHALL be ignored and SHALL NOT set a pending flag.
REQ-024 bus_done outside WAIT SHALL be ignored.
REQ-025 Transaction latency SHALL be START(1) + WAIT(n) + NEXT(1) cycles per register; a full 10-register read sweep takes 30 cycles with bus_done 1 cycle after bus_start.

Reset
REQ-026 On reset low, SHALL asynchronously enter IDLE with bus_start=0, bus_wr=0, idx_reg=0, ld_reg=0, busy=0, err_timeout=0, pending flags cleared.
REQ-027 Reset mid-sweep SHALL abort immediately; no bus_start or ld_reg pulse SHALL follow release until a new request.

Configuration
REQ-028 With SECUENCIADOR_TIMEOUT_EN defined, a WAIT counter SHALL abort the sweep to IDLE after TIMEOUT_CYC cycles without bus_done and set err_timeout, cleared only by reset or the next successful sweep completion.
REQ-029 Without SECUENCIADOR_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_timeout SHALL be tied to 0.

Structure
REQ-030 Shared package SHALL hold the state enumeration, register index constants 0..9, group codes 001/010/100 and mask width 10.
REQ-031 Edit-mask decode SHALL be a combinational sub-module named mascara_grupo_rtc.

Verification
REQ-032 funcion_conf=000, tick_refresco, bus_done 1 cycle after each bus_start -> 10 reads idx 0..9, 10 ld_reg pulses, busy low after 30 cycles.
REQ-033 funcion_conf=001, commit -> 3 writes idx 0,1,2 with bus_wr=1, no ld_reg; then tick -> 7 reads idx 3..9.
REQ-034 commit and tick_refresco same cycle with funcion_conf=100 -> writes idx 7,8,9, then reads idx 0..6 without a further tick.
REQ-035 funcion_conf=011, commit -> no bus_start, busy stays 0.
REQ-036 Timeout build, TIMEOUT_CYC=255, bus_done withheld -> abort to IDLE 255 cycles into WAIT, err_timeout=1; next full sweep clears it.
REQ-037 reset asserted during WAIT of idx 4 -> all outputs 0 asynchronously, no activity after release until new tick.
